// File: rtl/carry_chain_seq_adder_pkg.sv
// Shared types and helpers for the slice-serial carry-chain adder.
package carry_chain_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_chain_seq_adder_slice.sv
// One SLICE_WIDTH-bit carry-chain segment: CARRY-style P/G ripple, LSB to MSB.
module carry_slice #(
  parameter int unsigned SLICE_WIDTH = 8
) (
  input  logic [SLICE_WIDTH-1:0] a,
  input  logic [SLICE_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [SLICE_WIDTH-1:0] sum,
  output logic                   cout
);

  logic [SLICE_WIDTH:0] c;
  logic                 p;
  logic                 g;

  always_comb begin
    c    = '0;
    sum  = '0;
    p    = 1'b0;
    g    = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE_WIDTH; i++) begin
      p        = a[i] ^ b[i];
      g        = a[i] & b[i];
      sum[i]   = p ^ c[i];
      c[i+1]   = p ? c[i] : g;
    end
    cout = c[SLICE_WIDTH];
  end

endmodule

// File: rtl/carry_chain_seq_adder.sv
// Time-shared carry-chain adder/subtractor: one slice per clock, carry registered
// between slices, valid/ready on both sides.
module carry_chain_seq_adder
  import carry_chain_seq_adder_pkg::*;
#(
  parameter  int unsigned SLICE_WIDTH = 8,
  parameter  int unsigned NUM_SLICES  = 4,
  localparam int unsigned DW          = SLICE_WIDTH * NUM_SLICES
) (
  input  logic          C,
  input  logic          R,
  input  logic          I_VALID,
  output logic          I_READY,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          CI,
  input  logic          SUB,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic [DW-1:0] SUM,
  output logic          CO,
  output logic          BUSY
);

  localparam int unsigned    CW   = cnt_width(NUM_SLICES);
  localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            carry_q, carry_d;
  logic [DW-1:0]   a_q,     a_d;
  logic [DW-1:0]   b_q,     b_d;
  logic [DW-1:0]   sum_q,   sum_d;
  logic            co_q,    co_d;

  logic [SLICE_WIDTH-1:0] slice_sum;
  logic                   slice_cout;
  logic                   accept;

  // Operands shift down and the result shifts in from the top, so the active
  // slice is always at bit 0 and slice k ends up at SUM[k*SLICE_WIDTH +: SLICE_WIDTH].
  carry_slice #(
    .SLICE_WIDTH(SLICE_WIDTH)
  ) u_slice (
    .a   (a_q[SLICE_WIDTH-1:0]),
    .b   (b_q[SLICE_WIDTH-1:0]),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  assign I_READY = R & ((state_q == IDLE) | ((state_q == DONE) & O_READY));
  assign accept  = I_VALID & I_READY;
  assign O_VALID = (state_q == DONE);
  assign BUSY    = (state_q != IDLE);
  assign SUM     = sum_q;
  assign CO      = co_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && O_READY) state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = A;
          b_d     = SUB ? ~B : B;
          carry_d = SUB | CI;
          sum_d   = '0;
          co_d    = 1'b0;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE_WIDTH;
        b_d     = b_q >> SLICE_WIDTH;
        sum_d   = {slice_sum, sum_q[DW-1:SLICE_WIDTH]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          co_d    = slice_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

endmodule

// File: tb/tb_carry_chain_seq_adder.sv
// Self-checking bench for carry_chain_seq_adder: vector table plus handshake corner cases.
module tb_carry_chain_seq_adder;

  localparam int DW   = 32;
  localparam int HALF = 5;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ci;
    logic          sub;
    logic [DW-1:0] exp_sum;
    logic          exp_co;
  } vec_t;

  typedef struct {
    logic [DW-1:0] sum;
    logic          co;
  } exp_t;

  logic          C, R, I_VALID, I_READY, CI, SUB, O_VALID, O_READY, CO, BUSY;
  logic [DW-1:0] A, B, SUM;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  time  hs_t[$];
  time  acc_t;

  carry_chain_seq_adder #(
    .SLICE_WIDTH(8),
    .NUM_SLICES (4)
  ) dut (
    .C      (C),
    .R      (R),
    .I_VALID(I_VALID),
    .I_READY(I_READY),
    .A      (A),
    .B      (B),
    .CI     (CI),
    .SUB    (SUB),
    .O_VALID(O_VALID),
    .O_READY(O_READY),
    .SUM    (SUM),
    .CO     (CO),
    .BUSY   (BUSY)
  );

  initial C = 1'b0;
  always #HALF C = ~C;

  function automatic vec_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic ci, input logic sub);
    vec_t v;
    logic [DW:0] r;
    r = sub ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci});
    v.a = a; v.b = b; v.ci = ci; v.sub = sub;
    v.exp_sum = r[DW-1:0];
    v.exp_co  = r[DW];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Result scoreboard: compare on the negedge before each output handshake edge.
  always @(negedge C) begin : monitor
    exp_t e;
    if (R && O_VALID && O_READY) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got SUM=%h CO=%b, required no output", SUM, CO);
      end else begin
        e = exp_q.pop_front();
        if (SUM !== e.sum || CO !== e.co) begin
          fails++;
          $display("FAIL result: got SUM=%h CO=%b, required SUM=%h CO=%b", SUM, CO, e.sum, e.co);
        end
      end
      hs_t.push_back($time);
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    ok = 0;
    A = v.a; B = v.b; CI = v.ci; SUB = v.sub; I_VALID = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge C);
      if (I_READY) begin
        @(posedge C);
        exp_q.push_back('{v.exp_sum, v.exp_co});
        acc_t = $time;
        ok = 1;
        #1;
      end
    end
    I_VALID = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!O_VALID && n < 20) begin
      @(posedge C);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(negedge C);
    @(posedge C);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tbl[$];
  vec_t v1, v2;
  int   lat, ovcnt, base;

  initial begin
    R = 1'b0; I_VALID = 1'b0; O_READY = 1'b1;
    A = '0; B = '0; CI = 1'b0; SUB = 1'b0;

    tbl.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
    tbl.push_back('{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1});
    tbl.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1});
    for (int i = 0; i < 4; i++)
      tbl.push_back(model($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1))));

    // Reset state
    #3;
    chk("rst_i_ready", 64'(I_READY), 64'd0);
    chk("rst_o_valid", 64'(O_VALID), 64'd0);
    chk("rst_busy",    64'(BUSY),    64'd0);
    chk("rst_sum",     64'(SUM),     64'd0);
    chk("rst_co",      64'(CO),      64'd0);
    @(posedge C); #1;
    R = 1'b1;
    #1;
    chk("post_rst_i_ready", 64'(I_READY), 64'd1);

    // Table vectors with latency check
    foreach (tbl[i]) begin
      send(tbl[i]);
      chk("busy_in_run", 64'(BUSY), 64'd1);
      wait_valid(lat);
      chk("latency", 64'(lat), 64'd4);
      drain();
    end

    // Backpressure: hold result three cycles with a pending request
    O_READY = 1'b0;
    v1 = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0};
    v2 = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h4B4B4B4B, 1'b1};
    send(v1);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd4);
    A = v2.a; B = v2.b; CI = v2.ci; SUB = v2.sub; I_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      chk("bp_o_valid", 64'(O_VALID), 64'd1);
      chk("bp_sum",     64'(SUM),     64'(v1.exp_sum));
      chk("bp_co",      64'(CO),      64'(v1.exp_co));
      chk("bp_i_ready", 64'(I_READY), 64'd0);
      chk("bp_busy",    64'(BUSY),    64'd1);
    end
    @(posedge C); #1;
    O_READY = 1'b1;
    send(v2);
    drain();

    // Back-to-back: second request accepted on the first output handshake edge
    base = hs_t.size();
    v1 = '{32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0};
    v2 = '{32'h00000010, 32'h00000020, 1'b0, 1'b1, 32'hFFFFFFF0, 1'b0};
    send(v1);
    send(v2);
    drain();
    if (hs_t.size() >= base + 2) begin
      chk("b2b_accept_on_hs", 64'(acc_t), 64'(hs_t[base] + HALF));
      chk("b2b_spacing",      64'(hs_t[base+1] - hs_t[base]), 64'(10 * HALF));
    end else begin
      chk("b2b_handshakes", 64'(hs_t.size() - base), 64'd2);
    end

    // Asynchronous reset during slice 2
    v1 = model(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
    send(v1);
    @(posedge C);
    @(posedge C);
    #2;
    R = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_i_ready", 64'(I_READY), 64'd0);
    chk("mid_rst_o_valid", 64'(O_VALID), 64'd0);
    chk("mid_rst_busy",    64'(BUSY),    64'd0);
    chk("mid_rst_sum",     64'(SUM),     64'd0);
    chk("mid_rst_co",      64'(CO),      64'd0);
    @(negedge C);
    R = 1'b1;
    #1;
    chk("mid_rst_release_i_ready", 64'(I_READY), 64'd1);
    ovcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge C);
      if (O_VALID) ovcnt++;
    end
    chk("mid_rst_no_o_valid", 64'(ovcnt), 64'd0);
    @(posedge C); #1;
    send('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0});
    wait_valid(lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_sum",     64'(SUM), 64'h23456789);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/carry_chain_seq_adder.md
Name: carry_chain_seq_adder

Overview:
- Sequencer that time-shares one SLICE_WIDTH-bit carry-chain segment to add or subtract NUM_SLICES*SLICE_WIDTH-bit operands, processing one slice per clock.
- The COUT -> next CIN link between slices is broken by a registered carry; the stored carry restarts the chain on the next slice.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out) in fabric arithmetic built from CARRY cells.

Parameters:
- SLICE_WIDTH, 8, bits per carry-chain segment (>=1)
- NUM_SLICES, 4, slices per operation (>=2); total width DW = SLICE_WIDTH*NUM_SLICES

Ports:
- C  input  1  clock, rising edge
- R  input  1  asynchronous active-low reset
- I_VALID  input  1  request valid
- I_READY  output  1  request accepted when I_VALID & I_READY at rising C
- A  input  DW  operand A, sampled on accept
- B  input  DW  operand B, sampled on accept
- CI  input  1  carry in for add; ignored when SUB=1
- SUB  input  1  1: A-B, computed as A + ~B + 1
- O_VALID  output  1  result valid
- O_READY  input  1  result consumed when O_VALID & O_READY at rising C
- SUM  output  DW  result
- CO  output  1  final carry out (for SUB: 1 = no borrow)
- BUSY  output  1  high in RUN and DONE

Behaviour:
- Reset (R=0, asynchronous): state=IDLE, slice counter=0, carry reg=0, operand/result regs=0, SUM=0, CO=0, O_VALID=0, BUSY=0, I_READY=0 while R low; I_READY=1 from first cycle after R deasserts.
- States: IDLE, RUN, DONE.
- I_READY = (state==IDLE) | (state==DONE & O_READY); combinational.
- Accept edge: latch A, (SUB ? ~B : B); carry reg <= SUB ? 1 : CI; counter <= 0; state <= RUN; result reg cleared.
- RUN, slice k = counter:
  - P = a_k ^ b_k, G = a_k & b_k per bit; carry ripples LSB->MSB.
  - Per bit: sum = P ^ cin; cout = P ? cin : G.
  - slice sum written to SUM[k*SLICE_WIDTH +: SLICE_WIDTH]; carry reg <= slice MSB cout.
  - counter increments; on k==NUM_SLICES-1: CO <= cout, state <= DONE, counter <= 0.
- Latency: O_VALID rises exactly NUM_SLICES rising edges after the accept edge.
- DONE: O_VALID=1; SUM/CO held stable until handshake.
  - O_READY=1, I_VALID=0: -> IDLE, O_VALID<=0.
  - O_READY=1, I_VALID=1: output handshake and new accept on the same edge, -> RUN (back-to-back); throughput one op per NUM_SLICES+1 cycles.
  - O_READY=0: hold; no accept.
- SUM partial slices are not valid while O_VALID=0; only the final value is architectural.
- Arithmetic is modulo 2^DW; no overflow flag.
- I_VALID in RUN is ignored; the requester must hold A/B/SUB/CI until its own accept.
- Reset mid-operation aborts with no output; same values as reset.
- Counter width: clog2(NUM_SLICES), minimum 1.

Decomposition:
- Shared package/header:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - counter-width function
- Sub-module carry_slice: combinational, SLICE_WIDTH-bit P/G ripple.
  - Inputs: a, b, cin. Outputs: sum, cout.
  - Per-bit function identical to CARRY: O = P^CIN, COUT = P ? CIN : G.
  - Instantiated once in the top.

Test Plan (defaults, DW=32):
- Add across one slice boundary: A=0x000000FF, B=0x00000001, CI=0, SUB=0 -> SUM=0x00000100, CO=0; O_VALID exactly 4 edges after accept.
- Full carry propagation: A=0xFFFFFFFF, B=0x00000001, CI=0 -> SUM=0x00000000, CO=1. Also A=0xFFFFFFFF, B=0, CI=1 -> same result.
- Subtract with borrow: A=5, B=7, SUB=1, CI=0 -> SUM=0xFFFFFFFE, CO=0. Then A=7, B=5 -> SUM=0x00000002, CO=1.
- Backpressure: O_READY=0 for 3 cycles after O_VALID -> SUM/CO/O_VALID stable, I_READY=0, pending I_VALID not accepted. Then O_READY=1 -> handshake.
- Back-to-back: I_VALID held with two requests, O_READY=1 -> second accepted on the same edge as first output handshake; results at cycle spacing 5.
- Reset mid-op: assert R=0 during RUN slice 2 -> all outputs 0 immediately (asynchronous). After release, I_READY=1 and no O_VALID pulse. Next op 0x12345678+0x11111111 -> SUM=0x23456789, CO=0.
